// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row sync, debounce, key entry shift.
// Optional KEYPAD_CLEAR_EN: accepting key C clears entry instead of shifting.
module keypad_scanner #(
   parameter int unsigned SCAN_DIVIDE    = 100000,
   parameter int unsigned DEBOUNCE_COUNT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  row,
   output logic [3:0]  column,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic [15:0] entry
);

   localparam int unsigned DW =
      (SCAN_DIVIDE > 1) ? $clog2(SCAN_DIVIDE) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIVIDE - 1);
   localparam logic [3:0]    DB_LAST  = 4'(DEBOUNCE_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    row_s1_q, srow_q;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [1:0]    cand_row_q, cand_row_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [3:0]    column_q, column_d;
   logic          key_valid_q, key_valid_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_held_q, key_held_d;
   logic [15:0]   entry_q, entry_d;

   logic          tick;
   logic [1:0]    low_row;
   logic          acc;
   logic [1:0]    acc_row;
   logic [3:0]    acc_code;

   function automatic logic [3:0] key_map(
      input logic [1:0] r,
      input logic [1:0] c
   );
      logic [3:0] k;
      unique case ({r, c})
         4'b0000: k = 4'h1;
         4'b0001: k = 4'h2;
         4'b0010: k = 4'h3;
         4'b0011: k = 4'hA;
         4'b0100: k = 4'h4;
         4'b0101: k = 4'h5;
         4'b0110: k = 4'h6;
         4'b0111: k = 4'hB;
         4'b1000: k = 4'h7;
         4'b1001: k = 4'h8;
         4'b1010: k = 4'h9;
         4'b1011: k = 4'hC;
         4'b1100: k = 4'h0;
         4'b1101: k = 4'hF;
         4'b1110: k = 4'hE;
         4'b1111: k = 4'hD;
      endcase
      return k;
   endfunction

   assign tick = (div_q == DIV_LAST);

   // Several keys in one column: lowest row index wins
   always_comb begin
      low_row = 2'd0;
      if (!srow_q[0])      low_row = 2'd0;
      else if (!srow_q[1]) low_row = 2'd1;
      else if (!srow_q[2]) low_row = 2'd2;
      else if (!srow_q[3]) low_row = 2'd3;
   end

   always_comb begin
      state_d     = state_q;
      div_d       = tick ? '0 : div_q + DW'(1);
      col_idx_d   = col_idx_q;
      cand_row_d  = cand_row_q;
      cnt_d       = cnt_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      key_held_d  = key_held_q;
      entry_d     = entry_q;
      acc         = 1'b0;
      acc_row     = cand_row_q;

      unique case (state_q)
         IDLE: begin
            if (tick) begin
               if (srow_q == 4'b1111) begin
                  col_idx_d = col_idx_q + 2'd1;
               end else begin
                  cand_row_d = low_row;
                  acc_row    = low_row;
                  if (DB_LAST == 4'd1) begin
                     acc = 1'b1;
                  end else begin
                     cnt_d   = 4'd1;
                     state_d = DEBOUNCE;
                  end
               end
            end
         end
         DEBOUNCE: begin
            if (tick) begin
               if (!srow_q[cand_row_q]) begin
                  if (cnt_q + 4'd1 == DB_LAST) acc = 1'b1;
                  else cnt_d = cnt_q + 4'd1;
               end else begin
                  state_d   = IDLE;
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
         end
         PRESSED: begin
            if (tick) begin
               if (srow_q[cand_row_q]) begin
                  if (cnt_q + 4'd1 == DB_LAST) begin
                     state_d    = IDLE;
                     key_held_d = 1'b0;
                     cnt_d      = 4'd0;
                     col_idx_d  = col_idx_q + 2'd1;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  cnt_d = 4'd0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      acc_code = key_map(acc_row, col_idx_q);
      if (acc) begin
         state_d     = PRESSED;
         cnt_d       = 4'd0;
         key_valid_d = 1'b1;
         key_code_d  = acc_code;
         key_held_d  = 1'b1;
`ifdef KEYPAD_CLEAR_EN
         entry_d = (acc_code == 4'hC) ? 16'h0000
                                      : {entry_q[11:0], acc_code};
`else
         entry_d = {entry_q[11:0], acc_code};
`endif
      end

      column_d = ~(4'b0001 << col_idx_d);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         row_s1_q    <= 4'b1111;
         srow_q      <= 4'b1111;
         state_q     <= IDLE;
         div_q       <= '0;
         col_idx_q   <= 2'd0;
         cand_row_q  <= 2'd0;
         cnt_q       <= 4'd0;
         column_q    <= 4'b1110;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         key_held_q  <= 1'b0;
         entry_q     <= 16'h0000;
      end else begin
         row_s1_q    <= row;
         srow_q      <= row_s1_q;
         state_q     <= state_d;
         div_q       <= div_d;
         col_idx_q   <= col_idx_d;
         cand_row_q  <= cand_row_d;
         cnt_q       <= cnt_d;
         column_q    <= column_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_held_q  <= key_held_d;
         entry_q     <= entry_d;
      end
   end

   assign column    = column_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_held  = key_held_q;
   assign entry     = entry_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed timing cases,
// table-driven key sequences and random presses against an entry model.
module tb_keypad_scanner;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row;
   logic [3:0]  column;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [15:0] entry;

   keypad_scanner #(
      .SCAN_DIVIDE   (4),
      .DEBOUNCE_COUNT(3)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .row      (row),
      .column   (column),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_held (key_held),
      .entry    (entry)
   );

   always #5 clock = ~clock;

`ifdef KEYPAD_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   // keys[r][c] = 1 means the switch at row r, column c is closed
   logic [3:0] keys [4];

   always_comb begin
      for (int r = 0; r < 4; r++) row[r] = ~|(keys[r] & ~column);
   end

   logic [3:0] mapk [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'h0, 4'hF, 4'hE, 4'hD}
   };

   int cyc;
   always @(posedge clock) begin
      if (reset) cyc <= 0;
      else cyc <= cyc + 1;
   end

   int pulses = 0;
   int pulse_cyc[$];
   bit prev_kv = 1'b0;
   bit back2back = 1'b0;
   always @(negedge clock) begin
      if (key_valid === 1'b1) begin
         pulses++;
         pulse_cyc.push_back(cyc);
         if (prev_kv) back2back = 1'b1;
      end
      prev_kv = (key_valid === 1'b1);
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic wait_until(input int n);
      int g = 0;
      while (cyc != n && g < 1000) begin
         step();
         g++;
      end
      if (g >= 1000) check("wait_cycle_timeout", 32'(cyc), 32'(n));
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic clear_keys();
      for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
   endtask

   task automatic press_key(input int r, input int c, input int hold,
                            input logic [3:0] code_exp,
                            input logic [15:0] entry_exp);
      int n0;
      int g;
      n0 = pulses;
      keys[r][c] = 1'b1;
      g = 0;
      while (pulses == n0 && g < 300) begin
         step();
         g++;
      end
      check("press_pulse_seen", 32'(pulses - n0), 32'd1);
      check("press_code", 32'(key_code), 32'(code_exp));
      check("press_entry", 32'(entry), 32'(entry_exp));
      check("press_held", 32'(key_held), 32'd1);
      repeat (hold) step();
      keys[r][c] = 1'b0;
      g = 0;
      while (key_held && g < 300) begin
         step();
         g++;
      end
      check("release_held", 32'(key_held), 32'd0);
      repeat (3) step();
      check("single_pulse", 32'(pulses - n0), 32'd1);
   endtask

   typedef struct {
      bit         rst;
      int         r;
      int         c;
      logic [3:0] code;
      logic [15:0] ent;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int n0;
      logic [15:0] m_entry;
      logic [3:0]  mc;
      int rr;
      int cc;

      clear_keys();
      tbl[0] = '{1'b1, 0, 0, 4'h1, 16'h0001};
      tbl[1] = '{1'b0, 0, 1, 4'h2, 16'h0012};
      tbl[2] = '{1'b0, 0, 2, 4'h3, 16'h0123};
      tbl[3] = '{1'b0, 1, 0, 4'h4, 16'h1234};
      tbl[4] = '{1'b0, 1, 1, 4'h5, 16'h2345};
      tbl[5] = '{1'b1, 0, 0, 4'h1, 16'h0001};
      tbl[6] = '{1'b0, 0, 1, 4'h2, 16'h0012};
      tbl[7] = '{1'b0, 0, 2, 4'h3, 16'h0123};
      tbl[8] = '{1'b0, 1, 0, 4'h4, 16'h1234};
      tbl[9] = '{1'b0, 2, 3, 4'hC, CLR_EN ? 16'h0000 : 16'h234C};

      // Reset state and idle column walk
      reset_dut();
      check("rst_column", 32'(column), 32'hE);
      check("rst_valid", 32'(key_valid), 32'd0);
      check("rst_code", 32'(key_code), 32'd0);
      check("rst_held", 32'(key_held), 32'd0);
      check("rst_entry", 32'(entry), 32'd0);
      wait_until(3);
      check("walk_c3", 32'(column), 32'hE);
      wait_until(4);
      check("walk_c4", 32'(column), 32'hD);
      wait_until(8);
      check("walk_c8", 32'(column), 32'hB);
      wait_until(12);
      check("walk_c12", 32'(column), 32'h7);
      wait_until(16);
      check("walk_c16", 32'(column), 32'hE);

      // Key 5 held: capture on tick at cycle 7, pulse at 7+2*4+1
      reset_dut();
      n0 = pulses;
      keys[1][1] = 1'b1;
      wait_until(15);
      check("k5_no_early", 32'(key_valid), 32'd0);
      wait_until(16);
      check("k5_valid", 32'(key_valid), 32'd1);
      check("k5_code", 32'(key_code), 32'h5);
      check("k5_entry", 32'(entry), 32'h0005);
      check("k5_held", 32'(key_held), 32'd1);
      wait_until(17);
      check("k5_valid_drop", 32'(key_valid), 32'd0);
      wait_until(20);
      keys[1][1] = 1'b0;
      wait_until(31);
      check("k5_held_c31", 32'(key_held), 32'd1);
      wait_until(32);
      check("k5_held_c32", 32'(key_held), 32'd0);
      check("k5_col_next", 32'(column), 32'hB);
      check("k5_one_pulse", 32'(pulses - n0), 32'd1);
      check("k5_pulse_cyc", 32'(pulse_cyc[pulse_cyc.size()-1]), 32'd16);

      // Bounce: key 1 low for two ticks then released
      reset_dut();
      n0 = pulses;
      keys[0][0] = 1'b1;
      wait_until(5);
      check("bnc_frozen", 32'(column), 32'hE);
      wait_until(8);
      keys[0][0] = 1'b0;
      wait_until(11);
      check("bnc_c11", 32'(column), 32'hE);
      wait_until(12);
      check("bnc_resume", 32'(column), 32'hD);
      check("bnc_no_pulse", 32'(pulses - n0), 32'd0);
      check("bnc_entry", 32'(entry), 32'd0);

      // Two keys in column 2, then reset while PRESSED
      reset_dut();
      keys[1][2] = 1'b1;
      keys[3][2] = 1'b1;
      wait_until(20);
      check("dual_valid", 32'(key_valid), 32'd1);
      check("dual_code", 32'(key_code), 32'h6);
      wait_until(22);
      reset = 1'b1;
      clear_keys();
      n0 = pulses;
      step();
      check("mid_rst_column", 32'(column), 32'hE);
      check("mid_rst_held", 32'(key_held), 32'd0);
      check("mid_rst_entry", 32'(entry), 32'd0);
      check("mid_rst_valid", 32'(key_valid), 32'd0);
      reset = 1'b0;
      repeat (40) step();
      check("mid_rst_no_pulse", 32'(pulses - n0), 32'd0);

      // Table-driven key sequences
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].rst) reset_dut();
         press_key(tbl[i].r, tbl[i].c, 2 + i, tbl[i].code, tbl[i].ent);
      end

      // Random presses against a key-entry model
      reset_dut();
      m_entry = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         rr = int'($urandom_range(0, 3));
         cc = int'($urandom_range(0, 3));
         mc = mapk[rr][cc];
         if (CLR_EN && mc == 4'hC) m_entry = 16'h0000;
         else m_entry = {m_entry[11:0], mc};
         press_key(rr, cc, int'($urandom_range(0, 30)), mc, m_entry);
         repeat ($urandom_range(0, 12)) step();
      end

      check("no_back_to_back", 32'(back2back), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
